// File: rtl/cdb_script_bfm.sv
// Script-RAM driven common-data-bus driver: plays loaded entries with hold counts, bubbles, loop/one-shot.
// Latency: entry 0 appears one cycle after start; all bus outputs registered. No backpressure: stall inserts bubbles.
// Optional saturating bus statistics counters when CDB_SCRIPT_BFM_STATS_EN is defined.
module cdb_script_bfm #(
   parameter int DEPTH  = 32,
   parameter int TAG_W  = 6,
   parameter int DATA_W = 32,
   parameter int HOLD_W = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ld_en,
   input  logic [$clog2(DEPTH)-1:0]   ld_addr,
   input  logic [TAG_W-1:0]           ld_tag,
   input  logic [DATA_W-1:0]          ld_data,
   input  logic [3:0]                 ld_flags,
   input  logic [HOLD_W-1:0]          ld_hold,
   input  logic                       len_we,
   input  logic [$clog2(DEPTH):0]     len,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       loop_en,
   input  logic                       stall,
   output logic [TAG_W-1:0]           cdb_tag,
   output logic                       cdb_valid,
   output logic [DATA_W-1:0]          cdb_data,
   output logic                       cdb_branch,
   output logic                       cdb_branch_taken,
   output logic                       cdb_jalr,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(DEPTH)-1:0]   cur_idx
`ifdef CDB_SCRIPT_BFM_STATS_EN
   ,
   output logic [15:0]                stat_valid_cnt,
   output logic [15:0]                stat_branch_cnt,
   output logic [15:0]                stat_taken_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   logic [TAG_W-1:0]  tag_mem  [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [3:0]        flag_mem [DEPTH];
   logic [HOLD_W-1:0] hold_mem [DEPTH];

   state_t            state, state_n;
   logic [AW-1:0]     ptr, ptr_n, ptr_inc;
   logic [HOLD_W-1:0] hold_cnt, hold_n;
   logic [LW-1:0]     len_r;
   logic              bubble_r, bubble_n;
   logic              load_en;
   logic [AW-1:0]     load_idx;
   logic              ld_ok, last;

   assign ld_ok   = ({1'b0, ld_addr} < LW'(DEPTH));
   assign ptr_inc = ptr + AW'(1);
   assign last    = (({1'b0, ptr} + LW'(1)) >= len_r);

   // RAM is deliberately not reset so a script survives a bench-level reset.
   always_ff @(posedge clk) begin
      if (ld_en && state != RUN && ld_ok) begin
         tag_mem[ld_addr]  <= ld_tag;
         data_mem[ld_addr] <= ld_data;
         flag_mem[ld_addr] <= ld_flags;
         hold_mem[ld_addr] <= ld_hold;
      end
   end

   always_comb begin
      state_n  = state;
      ptr_n    = ptr;
      hold_n   = hold_cnt;
      bubble_n = 1'b0;
      load_en  = 1'b0;
      load_idx = ptr;
      case (state)
         IDLE, DONE: begin
            if (start && len_r != '0) begin
               state_n  = RUN;
               ptr_n    = '0;
               hold_n   = hold_mem[0];
               load_en  = 1'b1;
               load_idx = '0;
            end
         end
         RUN: begin
            if (stop) begin
               state_n = IDLE;
               ptr_n   = '0;
               hold_n  = '0;
            end else if (stall) begin
               bubble_n = 1'b1;
            end else if (bubble_r) begin
               // leaving a bubble: re-present the interrupted entry without consuming hold
               load_en = 1'b1;
            end else if (hold_cnt != '0) begin
               load_en = 1'b1;
               hold_n  = hold_cnt - HOLD_W'(1);
            end else if (!last) begin
               ptr_n    = ptr_inc;
               load_idx = ptr_inc;
               load_en  = 1'b1;
               hold_n   = hold_mem[ptr_inc];
            end else if (loop_en) begin
               ptr_n    = '0;
               load_idx = '0;
               load_en  = 1'b1;
               hold_n   = hold_mem[0];
            end else begin
               state_n = DONE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         ptr              <= '0;
         hold_cnt         <= '0;
         len_r            <= '0;
         bubble_r         <= 1'b0;
         cdb_tag          <= '0;
         cdb_valid        <= 1'b0;
         cdb_data         <= '0;
         cdb_branch       <= 1'b0;
         cdb_branch_taken <= 1'b0;
         cdb_jalr         <= 1'b0;
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         hold_cnt <= hold_n;
         bubble_r <= bubble_n;
         if (len_we && state != RUN)
            len_r <= (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
         cdb_tag          <= load_en ? tag_mem[load_idx]     : '0;
         cdb_data         <= load_en ? data_mem[load_idx]    : '0;
         cdb_valid        <= load_en & flag_mem[load_idx][0];
         cdb_branch       <= load_en & flag_mem[load_idx][1];
         cdb_branch_taken <= load_en & flag_mem[load_idx][2];
         cdb_jalr         <= load_en & flag_mem[load_idx][3];
      end
   end

   assign busy    = (state == RUN);
   assign done    = (state == DONE);
   assign cur_idx = (state == RUN) ? ptr : '0;

`ifdef CDB_SCRIPT_BFM_STATS_EN
   logic start_run;
   assign start_run = (state != RUN) && start && (len_r != '0);

   always_ff @(posedge clk) begin
      if (rst || start_run) begin
         stat_valid_cnt  <= '0;
         stat_branch_cnt <= '0;
         stat_taken_cnt  <= '0;
      end else begin
         if (cdb_valid && stat_valid_cnt != 16'hFFFF)
            stat_valid_cnt <= stat_valid_cnt + 16'd1;
         if (cdb_branch && stat_branch_cnt != 16'hFFFF)
            stat_branch_cnt <= stat_branch_cnt + 16'd1;
         if (cdb_branch_taken && stat_taken_cnt != 16'hFFFF)
            stat_taken_cnt <= stat_taken_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cdb_script_bfm.sv
// Directed bench for cdb_script_bfm: load, hold, stall, branch-only, loop/stop, len=0, load-during-run.
module tb_cdb_script_bfm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_en = 1'b0;
   logic [4:0]  ld_addr = '0;
   logic [5:0]  ld_tag = '0;
   logic [31:0] ld_data = '0;
   logic [3:0]  ld_flags = '0;
   logic [3:0]  ld_hold = '0;
   logic        len_we = 1'b0;
   logic [5:0]  len = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop_en = 1'b0;
   logic        stall = 1'b0;
   logic [5:0]  cdb_tag;
   logic        cdb_valid;
   logic [31:0] cdb_data;
   logic        cdb_branch;
   logic        cdb_branch_taken;
   logic        cdb_jalr;
   logic        busy;
   logic        done;
   logic [4:0]  cur_idx;
`ifdef CDB_SCRIPT_BFM_STATS_EN
   logic [15:0] stat_valid_cnt, stat_branch_cnt, stat_taken_cnt;
`endif

   int checks = 0;
   int fails  = 0;

   cdb_script_bfm #(.DEPTH(32), .TAG_W(6), .DATA_W(32), .HOLD_W(4)) dut (
      .clk(clk), .rst(rst),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_tag(ld_tag), .ld_data(ld_data),
      .ld_flags(ld_flags), .ld_hold(ld_hold),
      .len_we(len_we), .len(len), .start(start), .stop(stop),
      .loop_en(loop_en), .stall(stall),
      .cdb_tag(cdb_tag), .cdb_valid(cdb_valid), .cdb_data(cdb_data),
      .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken), .cdb_jalr(cdb_jalr),
      .busy(busy), .done(done), .cur_idx(cur_idx)
`ifdef CDB_SCRIPT_BFM_STATS_EN
      , .stat_valid_cnt(stat_valid_cnt), .stat_branch_cnt(stat_branch_cnt),
      .stat_taken_cnt(stat_taken_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 ns after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int a, input int t, input int d, input int f, input int h);
      ld_en = 1'b1; ld_addr = 5'(a); ld_tag = 6'(t); ld_data = 32'(d);
      ld_flags = 4'(f); ld_hold = 4'(h);
      tick();
      ld_en = 1'b0;
   endtask

   task automatic set_len(input int n);
      len_we = 1'b1; len = 6'(n);
      tick();
      len_we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if ({cdb_tag, cdb_valid, cdb_data, cdb_branch, cdb_branch_taken, cdb_jalr} !== '0) begin
         fails++; $display("FAIL reset_bus got tag=%0d v=%0b data=%0h exp all zero", cdb_tag, cdb_valid, cdb_data);
      end
      checks++;
      if ({busy, done, cur_idx} !== 7'd0) begin
         fails++; $display("FAIL reset_status got busy=%0b done=%0b idx=%0d exp 0/0/0", busy, done, cur_idx);
      end
   endtask

   task automatic test_basic();
      int exp_data [3] = '{32'h0A, 32'h0B, 32'h15};
      load(0, 0, 32'h0A, 4'b0001, 0);
      load(1, 1, 32'h0B, 4'b0001, 0);
      load(2, 2, 32'h15, 4'b0001, 0);
      set_len(3);
      loop_en = 1'b0;
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (cdb_tag !== 6'(i) || cdb_valid !== 1'b1 || cdb_data !== exp_data[i] || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_cycle%0d got tag=%0d v=%0b data=%0h busy=%0b exp tag=%0d v=1 data=%0h busy=1",
                     i + 1, cdb_tag, cdb_valid, cdb_data, busy, i, exp_data[i]);
         end
         tick();
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || cdb_valid !== 1'b0 || cdb_tag !== 6'd0 || cdb_data !== 32'd0) begin
         fails++; $display("FAIL basic_done got done=%0b busy=%0b v=%0b tag=%0d exp done=1 busy=0 v=0 tag=0",
                           done, busy, cdb_valid, cdb_tag);
      end
`ifdef CDB_SCRIPT_BFM_STATS_EN
      checks++;
      if (stat_valid_cnt !== 16'd3 || stat_branch_cnt !== 16'd0) begin
         fails++; $display("FAIL stats_valid got valid=%0d branch=%0d exp 3/0", stat_valid_cnt, stat_branch_cnt);
      end
`endif
   endtask

   task automatic test_hold();
      int exp_idx [5] = '{0, 1, 1, 1, 2};
      load(1, 1, 32'h0B, 4'b0001, 2);
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (cur_idx !== 5'(exp_idx[i]) || cdb_tag !== 6'(exp_idx[i]) || cdb_valid !== 1'b1) begin
            fails++; $display("FAIL hold_cycle%0d got idx=%0d tag=%0d v=%0b exp idx=tag=%0d v=1",
                              i + 1, cur_idx, cdb_tag, cdb_valid, exp_idx[i]);
         end
         tick();
      end
      checks++;
      if (done !== 1'b1 || cdb_valid !== 1'b0) begin
         fails++; $display("FAIL hold_done got done=%0b v=%0b exp 1/0", done, cdb_valid);
      end
   endtask

   task automatic test_stall();
      // -1 marks a bubble cycle
      int exp_tag [5] = '{1, -1, -1, 1, 2};
      load(1, 1, 32'h0B, 4'b0001, 0);
      pulse_start();
      tick();
      for (int i = 0; i < 5; i++) begin
         stall = (i < 2);
         checks++;
         if (exp_tag[i] < 0) begin
            if (cdb_valid !== 1'b0 || cdb_tag !== 6'd0 || cdb_data !== 32'd0 || busy !== 1'b1) begin
               fails++; $display("FAIL stall_bubble%0d got v=%0b tag=%0d busy=%0b exp v=0 tag=0 busy=1",
                                 i, cdb_valid, cdb_tag, busy);
            end
         end else if (cdb_valid !== 1'b1 || cdb_tag !== 6'(exp_tag[i])) begin
            fails++; $display("FAIL stall_entry%0d got v=%0b tag=%0d exp v=1 tag=%0d", i, cdb_valid, cdb_tag, exp_tag[i]);
         end
         tick();
      end
      stall = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         fails++; $display("FAIL stall_done got done=%0b exp 1", done);
      end
   endtask

   task automatic test_branch_only();
      load(0, 5, 32'h33, 4'b0110, 0);
      set_len(1);
      pulse_start();
      checks++;
      if (cdb_branch !== 1'b1 || cdb_branch_taken !== 1'b1 || cdb_valid !== 1'b0 ||
          cdb_jalr !== 1'b0 || cdb_tag !== 6'd5 || cdb_data !== 32'h33) begin
         fails++; $display("FAIL branch_only got br=%0b tk=%0b v=%0b j=%0b tag=%0d data=%0h exp 1/1/0/0/5/33",
                           cdb_branch, cdb_branch_taken, cdb_valid, cdb_jalr, cdb_tag, cdb_data);
      end
      tick();
      checks++;
      if (cdb_branch !== 1'b0 || done !== 1'b1) begin
         fails++; $display("FAIL branch_end got br=%0b done=%0b exp 0/1", cdb_branch, done);
      end
   endtask

   task automatic test_loop_stop();
      load(0, 0, 32'h0A, 4'b0001, 0);
      load(1, 1, 32'h0B, 4'b0001, 0);
      set_len(2);
      loop_en = 1'b1;
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (cdb_valid !== 1'b1 || cdb_tag !== 6'(i % 2)) begin
            fails++; $display("FAIL loop_cycle%0d got v=%0b tag=%0d exp v=1 tag=%0d", i, cdb_valid, cdb_tag, i % 2);
         end
         if (i < 4) tick();
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if (cdb_valid !== 1'b0 || cdb_tag !== 6'd0 || busy !== 1'b0 || done !== 1'b0 || cur_idx !== 5'd0) begin
         fails++; $display("FAIL loop_stop got v=%0b tag=%0d busy=%0b done=%0b idx=%0d exp all 0",
                           cdb_valid, cdb_tag, busy, done, cur_idx);
      end
      loop_en = 1'b0;
   endtask

   task automatic test_len_zero();
      set_len(0);
      pulse_start();
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || cdb_valid !== 1'b0) begin
         fails++; $display("FAIL len_zero got busy=%0b done=%0b v=%0b exp 0/0/0", busy, done, cdb_valid);
      end
   endtask

   task automatic test_load_during_run();
      load(0, 6'h10, 32'h100, 4'b0001, 0);
      load(1, 6'h11, 32'h101, 4'b0001, 0);
      set_len(2);
      loop_en = 1'b1;
      pulse_start();
      load(1, 6'h3F, 32'hDEAD, 4'b1111, 3);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      loop_en = 1'b0;
      pulse_start();
      tick();
      checks++;
      if (cdb_tag !== 6'h11 || cdb_data !== 32'h101 || cdb_jalr !== 1'b0) begin
         fails++; $display("FAIL load_in_run got tag=%0h data=%0h jalr=%0b exp tag=11 data=101 jalr=0",
                           cdb_tag, cdb_data, cdb_jalr);
      end
      tick();
      checks++;
      if (done !== 1'b1) begin
         fails++; $display("FAIL load_in_run_done got done=%0b exp 1", done);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_stall();
      test_branch_only();
      test_loop_stop();
      test_len_zero();
      test_load_during_run();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/cdb_script_bfm.md
Name: cdb_script_bfm

Overview:
- Parametrised, runtime-programmable bus-functional model that drives the common data bus (tag, valid, data, branch, branch_taken, jalr) from a loadable script RAM.
- Successor to the fixed-table CDB drivers in the dispatcher testbenches.
- Adds per-entry hold counts, stall bubbles, loop/one-shot modes, start/stop control and a programmable script length.
- Used only in simulation benches that exercise the dispatch unit and its queues.

Parameters:
DEPTH, 32, number of script entries (2..256)
TAG_W, 6, CDB tag width
DATA_W, 32, CDB data width
HOLD_W, 4, per-entry hold-count width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
ld_en  in  1  write script entry
ld_addr  in  $clog2(DEPTH)  entry index
ld_tag  in  TAG_W  entry tag
ld_data  in  DATA_W  entry data
ld_flags  in  4  {jalr, branch_taken, branch, valid}
ld_hold  in  HOLD_W  extra cycles entry stays on bus
len_we  in  1  write script length
len  in  $clog2(DEPTH)+1  entries to play (1..DEPTH)
start  in  1  begin playback from entry 0
stop  in  1  abort playback
loop_en  in  1  1: wrap to entry 0 after last; 0: one-shot
stall  in  1  insert bubble, freeze position
cdb_tag  out  TAG_W  bus tag
cdb_valid  out  1  bus valid
cdb_data  out  DATA_W  bus data
cdb_branch  out  1  branch-resolved flag
cdb_branch_taken  out  1  branch-taken flag
cdb_jalr  out  1  jalr flag
busy  out  1  state RUN
done  out  1  state DONE
cur_idx  out  $clog2(DEPTH)  entry currently on bus

Behaviour:
- Reset:
  - state IDLE; len_r=0; ptr=0; hold_cnt=0.
  - All cdb_* outputs, busy, done and cur_idx are 0.
  - Script RAM is not cleared.
- All cdb_* outputs are registered.
- Outputs are all-zero whenever state is not RUN, or a bubble is inserted.
- Script load:
  - ld_en writes the entry on the edge when state != RUN.
  - Ignored while RUN, or when ld_addr >= DEPTH.
  - len_we latches len on the same terms.
  - Values above DEPTH clamp to DEPTH; 0 is stored as 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE, start=1, len_r>0 → RUN. On that edge: ptr=0, hold_cnt=hold[0], outputs load entry 0. Entry 0 is visible the cycle after start.
  - start with len_r=0 is ignored.
  - RUN, stop=1 → IDLE. Outputs are zero the next cycle. stop beats start and stall.
  - RUN, stall=1 → stay RUN. Outputs load zeros (bubble). ptr and hold_cnt are unchanged. The same entry is re-presented after the stall with its remaining hold.
  - RUN, stall=0, hold_cnt>0 → outputs reload entry[ptr]; hold_cnt decrements.
  - RUN, stall=0, hold_cnt=0, ptr<len_r-1 → ptr+1; outputs load the next entry; hold_cnt reloads from that entry.
  - RUN, stall=0, hold_cnt=0, ptr=len_r-1:
    - loop_en=1 → ptr=0, entry 0 reloaded, stay RUN (seamless wrap, no gap cycle).
    - loop_en=0 → DONE, outputs zero.
  - DONE holds until start (restart) or rst.
- Each entry occupies hold+1 non-stalled cycles on the bus.
- An entry with valid flag 0 still drives its tag/data/branch fields. This is used for branch-only broadcasts.
- cur_idx = ptr of the entry on the bus; 0 in IDLE.
- loop_en is sampled only at the wrap decision.
- rst mid-RUN → IDLE with all outputs 0 the next cycle.

Optional Feature:
- Macro CDB_SCRIPT_BFM_STATS_EN.
- Defined: adds output ports stat_valid_cnt (16 bits), stat_branch_cnt (16 bits) and stat_taken_cnt (16 bits).
  - Each increments once per bus cycle on which the corresponding output (cdb_valid, cdb_branch, cdb_branch_taken) is 1.
  - All three saturate at 16'hFFFF.
  - All three clear on rst and on a start edge that enters RUN.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load 3 entries {tag 0, data 0x0A, valid}, {tag 1, data 0x0B, valid}, {tag 2, data 0x15, valid}, all hold 0; len=3, loop_en=0; pulse start → tags 0,1,2 with valid=1 on cycles 1-3 after start; cycle 4: DONE, done=1, outputs 0.
- Entry 1 hold=2 → tag 1 on bus for 3 consecutive cycles; total play 5 cycles; cur_idx sequence 0,1,1,1,2.
- stall=1 for 2 cycles while entry 1 (hold 0) is on bus → two zero cycles, then entry 1 re-presented once, then entry 2; no entry skipped.
- Entry {branch=1, branch_taken=1, valid=0} → cdb_branch=cdb_branch_taken=1, cdb_valid=0 for one cycle.
- loop_en=1, len=2 → tags 0,1,0,1… with no gap cycle; stop asserted → next cycle all outputs 0, busy=0, done=0.
- len=0 then start → stays IDLE. ld_en during RUN → RAM unchanged, confirmed by the next playback. With CDB_SCRIPT_BFM_STATS_EN defined, the 3-entry run gives stat_valid_cnt=3.
